// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with HI/LO registers and MTHI/MTLO writes
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  logic              busy_q, wr_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  hi_q, lo_q, res_hi_q, res_lo_q, res_hi_d, res_lo_d;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]  a_mag, b_mag, b_safe, uq, ur;
  logic              is_md, is_div, sgn, div0;
  assign is_md  = ~op[2];
  assign is_div = ~op[2] & op[1];
  assign sgn    = ~op[0];
  assign div0   = is_div & (B == '0);
  // Result is computed from the operands at acceptance and parked until the latency expires;
  // signed division works on magnitudes so the most-negative/-1 case wraps to A with no remainder.
  always_comb begin
    prod_s   = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
    prod_u   = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    a_mag    = (sgn & A[WIDTH-1]) ? -A : A;
    b_mag    = (sgn & B[WIDTH-1]) ? -B : B;
    b_safe   = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    uq       = a_mag / b_safe;
    ur       = a_mag % b_safe;
    res_lo_d = is_div ? ((sgn & (A[WIDTH-1] ^ B[WIDTH-1])) ? -uq : uq)
                      : (op[0] ? prod_u[WIDTH-1:0] : prod_s[WIDTH-1:0]);
    res_hi_d = is_div ? ((sgn & A[WIDTH-1]) ? -ur : ur)
                      : (op[0] ? prod_u[2*WIDTH-1:WIDTH] : prod_s[2*WIDTH-1:WIDTH]);
  end
  // Busy countdown, commit of the parked result (skipped on divide by zero), and MTHI/MTLO writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q   <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
        wr_q   <= 1'b0;
        if (wr_q) begin
          hi_q <= res_hi_q;
          lo_q <= res_lo_q;
        end
      end else cnt_q <= cnt_q - 1'b1;
    end else if (start) begin
      if (is_md) begin
        busy_q   <= 1'b1;
        cnt_q    <= is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
        wr_q     <= ~div0;
        res_hi_q <= res_hi_d;
        res_lo_q <= res_lo_d;
      end else if (op == 3'd4) hi_q <= A;
      else if (op == 3'd5) lo_q <= A;
    end
  end
  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: randomized and directed checks of mdu_unit against an arithmetic reference model
module tb_mdu_unit;
  logic        clk = 1'b0;
  logic        reset, start, start8, busy, busy8;
  logic [2:0]  op, op8;
  logic [31:0] a, b, hi, lo;
  logic [7:0]  a8, b8, hi8, lo8;
  int          n_eval = 0, n_fail = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;
  always #5 clk = ~clk;
  mdu_unit dut (.clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b),
                .busy(busy), .hi(hi), .lo(lo));
  mdu_unit #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .A(a8), .B(b8),
    .busy(busy8), .hi(hi8), .lo(lo8));
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_eval++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  function automatic int lat(input logic [2:0] o);
    return (o < 3'd2) ? 5 : ((o < 3'd4) ? 10 : 0);
  endfunction
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p;
    logic [63:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = sx * sy; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      3'd1: begin u = {32'd0, x} * {32'd0, y}; exp_hi = u[63:32]; exp_lo = u[31:0]; end
      3'd2: if (y != 0) begin p = sx / sy; exp_lo = p[31:0]; p = sx % sy; exp_hi = p[31:0]; end
      3'd3: if (y != 0) begin exp_lo = x / y; exp_hi = x % y; end
      3'd4: exp_hi = x;
      3'd5: exp_lo = x;
      default: ;
    endcase
  endtask
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input bit poke);
    int cyc;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      if (poke) begin start = 1'b1; op = 3'd3; a = 100; b = 7; end
      check({tag, " hold hi"}, 64'(hi), 64'(exp_hi));
      check({tag, " hold lo"}, 64'(lo), 64'(exp_lo));
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    model(o, x, y);
    check({tag, " busy cycles"}, 64'(cyc), 64'(lat(o)));
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
  endtask
  task automatic run8(input string tag, input logic [2:0] o, input logic [7:0] x,
                      input logic [7:0] y, input int n, input logic [7:0] eh, input logic [7:0] el);
    int cyc;
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    cyc = 0;
    while (busy8 === 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " busy cycles"}, 64'(cyc), 64'(n));
    check({tag, " hi"}, 64'(hi8), 64'(eh));
    check({tag, " lo"}, 64'(lo8), 64'(el));
  endtask
  initial begin
    logic [2:0]  o;
    logic [31:0] x, y;
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    #12;
    check("reset busy", 64'(busy), 64'(0));
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));
    check("reset busy8", 64'(busy8), 64'(0));
    @(negedge clk) reset = 1'b1;
    run("mult", 3'd0, 32'hFFFFFFFF, 32'h2, 1'b0);
    check("mult hi const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    check("mult lo const", 64'(lo), 64'h0000_0000_FFFF_FFFE);
    run("multu", 3'd1, 32'hFFFFFFFF, 32'h2, 1'b0);
    check("multu hi const", 64'(hi), 64'h1);
    run("div neg", 3'd2, 32'hFFFFFFF9, 32'h2, 1'b0);
    check("div lo const", 64'(lo), 64'hFFFF_FFFD);
    run("div ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("div ovf lo const", 64'(lo), 64'h8000_0000);
    check("div ovf hi const", 64'(hi), 64'h0);
    run("mthi", 3'd4, 32'h12345678, 32'h0, 1'b0);
    run("mtlo", 3'd5, 32'h9ABCDEF0, 32'h0, 1'b0);
    run("divu by zero", 3'd3, 32'h7, 32'h0, 1'b0);
    check("div0 hi const", 64'(hi), 64'h1234_5678);
    run("mtlo zero", 3'd5, 32'h0, 32'h0, 1'b0);
    run("start ignored", 3'd0, 32'h3, 32'h4, 1'b1);
    check("ignored lo const", 64'(lo), 64'd12);
    repeat (3) begin
      @(posedge clk); #1;
      check("no second busy", 64'(busy), 64'(0));
    end
    check("ignored hi after", 64'(hi), 64'(0));
    check("ignored lo after", 64'(lo), 64'd12);
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      x = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'h0 :
          (($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom);
      run("random", o, x, y, 1'b0);
    end
    run("pre-reset mthi", 3'd4, 32'hAAAA5555, 32'h0, 1'b0);
    run("pre-reset mtlo", 3'd5, 32'h5555AAAA, 32'h0, 1'b0);
    @(negedge clk);
    op = 3'd2; a = 32'h64; b = 32'h3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b0; #1;
    exp_hi = '0; exp_lo = '0;
    check("async reset busy", 64'(busy), 64'(0));
    check("async reset hi", 64'(hi), 64'(0));
    check("async reset lo", 64'(lo), 64'(0));
    @(negedge clk) reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post reset busy", 64'(busy), 64'(0));
    check("post reset hi", 64'(hi), 64'(0));
    check("post reset lo", 64'(lo), 64'(0));
    run8("w8 mult", 3'd0, 8'h80, 8'h80, 1, 8'h40, 8'h00);
    run8("w8 div ovf", 3'd2, 8'h80, 8'hFF, 3, 8'h00, 8'h80);
    run8("w8 div neg", 3'd2, 8'hF9, 8'h02, 3, 8'hFF, 8'hFD);
    run8("w8 divu", 3'd3, 8'hC8, 8'h07, 3, 8'h04, 8'h1C);
    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end
endmodule
